// File: rtl/aes256_key_expansion_pkg.sv
// Shared types and constants for the AES-256 key schedule: FSM states, word type, Rcon, S-box.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aes_pkg;

  localparam int NK = 8;
  localparam int NR = 14;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef logic [31:0] word_t;

  // Index 0 is unused; the schedule only needs Rcon[1..7] for Nk=8.
  localparam logic [0:7][7:0] RCON = {8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  // Forward S-box, entry 0 leftmost.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

endpackage

// File: rtl/aes256_key_expansion_if.sv
// Key-load / round-key handshake bundle: ready/valid key in, valid/yumi schedule out.
// Latency: n/a (wiring only).
// Backpressure: producer holds v_i until ready_o; consumer holds off yumi_i to keep v_o.
interface aes256_key_expansion_if;

  logic [0:255]  initial_key;
  logic          v_i;
  logic          ready_o;
  logic [0:1919] round_keys;
  logic          v_o;
  logic          yumi_i;

  modport master (
    output initial_key, v_i, yumi_i,
    input  ready_o, round_keys, v_o
  );

  modport slave (
    input  initial_key, v_i, yumi_i,
    output ready_o, round_keys, v_o
  );

endinterface

// File: rtl/aes256_key_expansion_sbox.sv
// Single AES forward S-box byte lookup.
// Latency: combinational.
// Backpressure: none.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  assign subst = SBOX[plain];

endmodule

// File: rtl/aes256_key_expansion.sv
// Iterative AES-256 key schedule: 4 words/cycle, one SubWord per cycle. Option: KEYEXP_ZEROIZE_EN.
// Latency: v_o rises 13 cycles after the accepting edge; one key per 14 cycles plus handshake.
// Backpressure: ready_o only in IDLE; result held in DONE until yumi_i.
module aes256_key_expansion
  import aes_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
  aes256_key_expansion_if.slave kif
);

  state_t        state;
  state_t        state_nxt;
  logic [3:0]    cnt;
  logic [0:1919] rk;
  logic [10:0]   base;
  logic          ready;
  logic          valid;
  word_t         w_prev [8];
  word_t         w_new  [4];
  word_t         sub_in;
  word_t         sub_out;
  logic [7:0]    rcon_b;
  logic [2:0]    rcon_idx;

  // Bit offset of w[i-8]; each step consumes 4 words = 128 bits.
  assign base = {cnt, 7'b0};

  // Window of the last eight schedule words, w[i-8..i-1].
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_prev[k] = rk[base + 11'(32 * k) +: 32];
    end
  end

  // Even steps start on j%8==0 (RotWord+Rcon), odd steps on j%8==4 (SubWord only).
  always_comb begin
    rcon_idx = 3'(cnt[3:1] + 3'd1);
    sub_in   = cnt[0] ? w_prev[7] : {w_prev[7][23:0], w_prev[7][31:24]};
    rcon_b   = cnt[0] ? 8'h00 : RCON[rcon_idx];
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox u_sbox (
        .plain (sub_in[8*g +: 8]),
        .subst (sub_out[8*g +: 8])
      );
    end
  endgenerate

  // Four chained words; only the first passes through the S-boxes.
  always_comb begin
    w_new[0] = w_prev[0] ^ sub_out ^ {rcon_b, 24'h0};
    w_new[1] = w_prev[1] ^ w_new[0];
    w_new[2] = w_prev[2] ^ w_new[1];
    w_new[3] = w_prev[3] ^ w_new[2];
  end

  // State register; reset aborts any expansion in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kif.v_i) state_nxt = BUSY;
      BUSY:    if (cnt == 4'(NR - 2)) state_nxt = DONE;
      DONE:    if (kif.yumi_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready = (state == IDLE);
    valid = (state == DONE);
  end

  // Counter and round-key register: load key, then append four words per cycle.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= 4'd0;
      rk  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (kif.v_i) begin
            rk  <= {kif.initial_key, 1664'b0};
            cnt <= 4'd0;
          end
        end
        BUSY: begin
          rk[base + 11'(32 * NK) +: 128] <= {w_new[0], w_new[1], w_new[2], w_new[3]};
          cnt <= cnt + 4'd1;
        end
        DONE: begin
`ifdef KEYEXP_ZEROIZE_EN
          if (kif.yumi_i) rk <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign kif.ready_o    = ready;
  assign kif.v_o        = valid;
  assign kif.round_keys = rk;

endmodule

// File: tb/tb_aes256_key_expansion.sv
// Directed bench for aes256_key_expansion against FIPS-197 vectors and an arithmetic key-schedule model.
// Latency: checks v_o arrives 13 cycles after acceptance.
// Backpressure: exercises held-off yumi_i, ignored v_i/yumi_i, and mid-expansion reset.
module tb_aes256_key_expansion;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes256_key_expansion_if kif ();

  aes256_key_expansion dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .kif     (kif)
  );

  localparam logic [0:255] KEY1  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:255] KEY64 = {32{8'h64}};
  localparam logic [0:255] KEYF  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] RK1_1  = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK1_2  = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] RK1_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK64   = {16{8'h64}};

  // Reference: S-box derived from GF(2^8) inverse and affine map, Rcon by doubling.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] b;
    logic [7:0] s;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    b = inv;
    s = inv ^ 8'h63;
    for (int i = 0; i < 4; i++) begin
      b = {b[6:0], b[7]};
      s = s ^ b;
    end
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
  endfunction

  function automatic logic [0:1919] model(input logic [0:255] key);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [0:1919] res;
    for (int k = 0; k < 8; k++) w[k] = key[32*k +: 32];
    for (int j = 8; j < 60; j++) begin
      t = w[j-1];
      if (j % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (j % 8 == 4) begin
        t = subw(t);
      end
      w[j] = w[j-8] ^ t;
    end
    for (int k = 0; k < 60; k++) res[32*k +: 32] = w[k];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] get_rk(input int r);
    return kif.round_keys[128*r +: 128];
  endfunction

  task automatic cmp_all(input string tag, input logic [0:1919] exp);
    for (int r = 0; r < 15; r++) chk($sformatf("%s_rk%0d", tag, r), get_rk(r), exp[128*r +: 128]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [0:255] key);
    int n = 0;
    while (!kif.ready_o && n < 40) begin
      tick();
      n++;
    end
    kif.initial_key = key;
    kif.v_i = 1'b1;
    tick();
    kif.v_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!kif.v_o && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic take();
    kif.yumi_i = 1'b1;
    tick();
    kif.yumi_i = 1'b0;
  endtask

  initial begin
    int            lat;
    int            bad;
    logic [127:0]  snap14;
    logic [127:0]  k0;
    logic [0:1919] snap;

    rst_n = 1'b0;
    kif.v_i = 1'b0;
    kif.yumi_i = 1'b0;
    kif.initial_key = '0;
    #12;
    chk("rst_ready", 128'(kif.ready_o), 128'd1);
    chk("rst_vo", 128'(kif.v_o), 128'd0);
    chk("rst_rk0", get_rk(0), 128'd0);
    chk("rst_rk14", get_rk(14), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Vector 1: FIPS-197 style key, latency and known round keys.
    accept(KEY1);
    chk("t1_busy_ready", 128'(kif.ready_o), 128'd0);
    wait_done(lat);
    chk("t1_latency", 128'(lat), 128'd13);
    k0 = KEY1[0:127];
    chk("t1_rk0", get_rk(0), k0);
    chk("t1_rk1", get_rk(1), RK1_1);
    chk("t1_rk2", get_rk(2), RK1_2);
    chk("t1_rk14", get_rk(14), RK1_14);
    cmp_all("t1", model(KEY1));
    snap14 = get_rk(14);
    take();
    chk("t1_idle_ready", 128'(kif.ready_o), 128'd1);
    chk("t1_idle_vo", 128'(kif.v_o), 128'd0);
`ifdef KEYEXP_ZEROIZE_EN
    chk("t6_zeroize_rk14", get_rk(14), 128'd0);
`else
    chk("t6_retain_rk14", get_rk(14), snap14);
`endif

    // Vector 2: repeated 0x64 key, then vector 1 back-to-back.
    accept(KEY64);
    wait_done(lat);
    chk("t2_latency", 128'(lat), 128'd13);
    chk("t2_rk0", get_rk(0), RK64);
    chk("t2_rk1", get_rk(1), RK64);
    cmp_all("t2", model(KEY64));
    kif.yumi_i = 1'b1;
    kif.v_i = 1'b1;
    kif.initial_key = KEY1;
    tick();
    kif.yumi_i = 1'b0;
    chk("t2_yumi_vi_not_taken", 128'(kif.ready_o), 128'd1);
    tick();
    kif.v_i = 1'b0;
    chk("t2_b2b_busy", 128'(kif.ready_o), 128'd0);
    wait_done(lat);
    chk("t2_b2b_latency", 128'(lat), 128'd13);
    cmp_all("t2b", model(KEY1));

    // Hold result for 20 cycles with yumi low and a stray key offered.
    snap = kif.round_keys;
    bad = 0;
    kif.v_i = 1'b1;
    kif.initial_key = KEY64;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (kif.round_keys !== snap || kif.v_o !== 1'b1 || kif.ready_o !== 1'b0) bad++;
    end
    kif.v_i = 1'b0;
    chk("t3_hold_bad_cycles", 128'(bad), 128'd0);
    chk("t3_hold_vo", 128'(kif.v_o), 128'd1);
    chk("t3_hold_rk14", get_rk(14), RK1_14);
    take();
    chk("t3_release_ready", 128'(kif.ready_o), 128'd1);
    chk("t3_release_vo", 128'(kif.v_o), 128'd0);

    // Asynchronous reset while cnt==6, then a clean expansion.
    accept(KEY64);
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_ready", 128'(kif.ready_o), 128'd1);
    chk("t4_rst_vo", 128'(kif.v_o), 128'd0);
    chk("t4_rst_rk0", get_rk(0), 128'd0);
    chk("t4_rst_rk2", get_rk(2), 128'd0);
    #2;
    rst_n = 1'b1;
    tick();
    accept(KEY1);
    wait_done(lat);
    chk("t4_latency", 128'(lat), 128'd13);
    cmp_all("t4", model(KEY1));
    take();

    // Key and v_i churn plus yumi during BUSY must not disturb the accepted key.
    accept(KEYF);
    for (int c = 0; c < 5; c++) begin
      kif.v_i = 1'b1;
      kif.yumi_i = 1'b1;
      kif.initial_key = KEY64 ^ {8{32'(c)}};
      tick();
    end
    kif.v_i = 1'b0;
    kif.yumi_i = 1'b0;
    wait_done(lat);
    chk("t5_latency", 128'(lat + 5), 128'd13);
    cmp_all("t5", model(KEYF));
    take();
    chk("t5_end_ready", 128'(kif.ready_o), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
